// File: rtl/multicycle_alu.sv
// Handshaked ALU (logic, add/sub with carry chaining, iterative shifts, shift-add multiply); latency 1, n+1 or WIDTH+1 cycles.
// InReady low while busy or holding a result; Result and flags stay frozen in DONE until OutReady.
module multicycle_alu #(
    parameter int WIDTH = 16
) (
    input  logic             Clock,
    input  logic             ResetN,
    input  logic             InValid,
    output logic             InReady,
    input  logic [4:0]       Opcode,
    input  logic [WIDTH-1:0] OperandA,
    input  logic [WIDTH-1:0] OperandB,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] Result,
    output logic             Carry,
    output logic             Overflow,
    output logic             Zero,
    output logic             Negative,
    output logic             Error
);

    localparam int SW = $clog2(WIDTH);

    localparam logic [4:0] OP_AND  = 5'd0;
    localparam logic [4:0] OP_OR   = 5'd1;
    localparam logic [4:0] OP_XOR  = 5'd2;
    localparam logic [4:0] OP_NOT  = 5'd3;
    localparam logic [4:0] OP_ADD  = 5'd4;
    localparam logic [4:0] OP_SUB  = 5'd5;
    localparam logic [4:0] OP_ADC  = 5'd6;
    localparam logic [4:0] OP_SBB  = 5'd7;
    localparam logic [4:0] OP_SHL  = 5'd8;
    localparam logic [4:0] OP_SHR  = 5'd9;
    localparam logic [4:0] OP_SAR  = 5'd10;
    localparam logic [4:0] OP_MULL = 5'd11;
    localparam logic [4:0] OP_MULH = 5'd12;

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    state_t             state, state_nxt;
    logic [4:0]         op;
    logic [WIDTH-1:0]   opa;
    logic [2*WIDTH-1:0] acc;
    logic [SW:0]        count;

    logic [SW-1:0]      amt;
    logic               is_shift, is_mul, go_exec, is_sub, add_cin, add_msb_cin;
    logic [WIDTH-1:0]   add_b;
    logic [WIDTH:0]     add_sum;
    logic [WIDTH-1:0]   shift_nxt;
    logic               shift_bit;
    logic [WIDTH:0]     mul_sum;
    logic [2*WIDTH-1:0] mul_nxt;
    logic               ld_out, carry_out, ovf_out, err_out;
    logic [WIDTH-1:0]   res_out;

    assign amt      = OperandB[SW-1:0];
    assign is_shift = (Opcode == OP_SHL) || (Opcode == OP_SHR) || (Opcode == OP_SAR);
    assign is_mul   = (Opcode == OP_MULL) || (Opcode == OP_MULH);
    assign go_exec  = is_mul || (is_shift && (amt != '0));

    // Subtraction runs through the same adder as A + ~B + cin, so borrow is the inverted carry-out.
    always_comb begin
        is_sub  = (Opcode == OP_SUB) || (Opcode == OP_SBB);
        add_b   = is_sub ? ~OperandB : OperandB;
        case (Opcode)
            OP_SUB:  add_cin = 1'b1;
            OP_ADC:  add_cin = Carry;
            OP_SBB:  add_cin = ~Carry;
            default: add_cin = 1'b0;
        endcase
        add_sum     = {1'b0, OperandA} + {1'b0, add_b} + {{WIDTH{1'b0}}, add_cin};
        add_msb_cin = OperandA[WIDTH-1] ^ add_b[WIDTH-1] ^ add_sum[WIDTH-1];
    end

    always_comb begin
        shift_nxt = opa;
        shift_bit = 1'b0;
        case (op)
            OP_SHL: begin shift_nxt = {opa[WIDTH-2:0], 1'b0};        shift_bit = opa[WIDTH-1]; end
            OP_SHR: begin shift_nxt = {1'b0, opa[WIDTH-1:1]};        shift_bit = opa[0];       end
            OP_SAR: begin shift_nxt = {opa[WIDTH-1], opa[WIDTH-1:1]}; shift_bit = opa[0];      end
            default: ;
        endcase
        // Low half of acc starts as the multiplier and is consumed one bit per step.
        mul_sum = {1'b0, acc[2*WIDTH-1:WIDTH]} + {1'b0, opa};
        mul_nxt = acc[0] ? {mul_sum, acc[WIDTH-1:1]} : {1'b0, acc[2*WIDTH-1:1]};
    end

    always_comb begin
        state_nxt = state;
        InReady   = (state == IDLE);
        OutValid  = (state == DONE);
        ld_out    = 1'b0;
        res_out   = '0;
        carry_out = Carry;
        ovf_out   = 1'b0;
        err_out   = 1'b0;
        case (state)
            IDLE: begin
                if (InValid) begin
                    if (go_exec) begin
                        state_nxt = EXEC;
                    end else begin
                        state_nxt = DONE;
                        ld_out    = 1'b1;
                        case (Opcode)
                            OP_AND: res_out = OperandA & OperandB;
                            OP_OR:  res_out = OperandA | OperandB;
                            OP_XOR: res_out = OperandA ^ OperandB;
                            OP_NOT: res_out = ~OperandA;
                            OP_ADD, OP_SUB, OP_ADC, OP_SBB: begin
                                res_out   = add_sum[WIDTH-1:0];
                                carry_out = is_sub ? ~add_sum[WIDTH] : add_sum[WIDTH];
                                ovf_out   = add_msb_cin ^ add_sum[WIDTH];
                            end
                            OP_SHL, OP_SHR, OP_SAR: res_out = OperandA;
                            default: err_out = 1'b1;
                        endcase
                    end
                end
            end
            EXEC: begin
                if (count == (SW+1)'(1)) begin
                    state_nxt = DONE;
                    ld_out    = 1'b1;
                    case (op)
                        OP_MULL: begin
                            res_out = mul_nxt[WIDTH-1:0];
                            ovf_out = |mul_nxt[2*WIDTH-1:WIDTH];
                        end
                        OP_MULH: res_out = mul_nxt[2*WIDTH-1:WIDTH];
                        default: begin
                            res_out   = shift_nxt;
                            carry_out = shift_bit;
                        end
                    endcase
                end
            end
            DONE: begin
                if (OutReady) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) state <= IDLE;
        else         state <= state_nxt;
    end

    always_ff @(posedge Clock or negedge ResetN) begin
        if (!ResetN) begin
            op       <= '0;
            opa      <= '0;
            acc      <= '0;
            count    <= '0;
            Result   <= '0;
            Carry    <= 1'b0;
            Overflow <= 1'b0;
            Zero     <= 1'b0;
            Negative <= 1'b0;
            Error    <= 1'b0;
        end else begin
            if (state == IDLE && InValid) begin
                op    <= Opcode;
                opa   <= OperandA;
                acc   <= {{WIDTH{1'b0}}, OperandB};
                count <= is_mul ? (SW+1)'(WIDTH) : {1'b0, amt};
            end else if (state == EXEC) begin
                opa   <= shift_nxt;
                acc   <= mul_nxt;
                count <= count - (SW+1)'(1);
            end
            if (ld_out) begin
                Result   <= res_out;
                Carry    <= carry_out;
                Overflow <= ovf_out;
                Zero     <= (res_out == '0);
                Negative <= res_out[WIDTH-1];
                Error    <= err_out;
            end
        end
    end

endmodule

// File: tb/tb_multicycle_alu.sv
// Scoreboard bench for multicycle_alu (WIDTH=16): expected records pushed at issue, popped at result.
module tb_multicycle_alu;

    logic        Clock = 1'b0;
    logic        ResetN = 1'b0;
    logic        InValid = 1'b0;
    logic        OutReady = 1'b0;
    logic [4:0]  Opcode = '0;
    logic [15:0] OperandA = '0;
    logic [15:0] OperandB = '0;
    logic        InReady, OutValid, Carry, Overflow, Zero, Negative, Error;
    logic [15:0] Result;

    multicycle_alu #(.WIDTH(16)) dut (
        .Clock(Clock), .ResetN(ResetN), .InValid(InValid), .InReady(InReady),
        .Opcode(Opcode), .OperandA(OperandA), .OperandB(OperandB),
        .OutValid(OutValid), .OutReady(OutReady), .Result(Result),
        .Carry(Carry), .Overflow(Overflow), .Zero(Zero), .Negative(Negative), .Error(Error)
    );

    always #5 Clock = ~Clock;

    typedef struct packed {
        logic [15:0] res;
        logic        c, v, z, n, e;
        logic [31:0] lat;
    } rec_t;

    rec_t sb[$];
    int   checks = 0;
    int   fails = 0;
    logic cf = 1'b0;

    function automatic string fmt(input rec_t r);
        return $sformatf("res=%h c=%b v=%b z=%b n=%b e=%b lat=%0d", r.res, r.c, r.v, r.z, r.n, r.e, r.lat);
    endfunction

    function automatic rec_t model(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b, input logic cin);
        rec_t        r;
        logic [16:0] s;
        logic [31:0] p;
        int          n;
        n = int'(b[3:0]);
        p = {16'h0, a} * {16'h0, b};
        r = '0;
        r.c = cin;
        r.lat = 1;
        case (op)
            5'd0: r.res = a & b;
            5'd1: r.res = a | b;
            5'd2: r.res = a ^ b;
            5'd3: r.res = ~a;
            5'd4, 5'd6: begin
                s = {1'b0, a} + {1'b0, b} + ((op == 5'd6) ? {16'h0, cin} : 17'h0);
                r.res = s[15:0]; r.c = s[16];
                r.v = (a[15] == b[15]) && (s[15] != a[15]);
            end
            5'd5, 5'd7: begin
                s = {1'b0, a} - {1'b0, b} - ((op == 5'd7) ? {16'h0, cin} : 17'h0);
                r.res = s[15:0]; r.c = s[16];
                r.v = (a[15] != b[15]) && (s[15] != a[15]);
            end
            5'd8, 5'd9, 5'd10: begin
                r.lat = 32'(n + 1);
                if (n == 0) r.res = a;
                else if (op == 5'd8) begin r.res = a << n; r.c = a[16-n]; end
                else if (op == 5'd9) begin r.res = a >> n; r.c = a[n-1]; end
                else begin r.res = 16'($signed(a) >>> n); r.c = a[n-1]; end
            end
            5'd11: begin r.res = p[15:0]; r.v = |p[31:16]; r.lat = 17; end
            5'd12: begin r.res = p[31:16]; r.lat = 17; end
            default: r.e = 1'b1;
        endcase
        r.z = (r.res == 16'h0);
        r.n = r.res[15];
        return r;
    endfunction

    // Issue one operation, push its expectation, wait (bounded) for the result, then take it.
    task automatic do_op(input logic [4:0] op, input logic [15:0] a, input logic [15:0] b, output rec_t got);
        rec_t e;
        int   w, lat;
        @(negedge Clock);
        w = 0;
        while (InReady !== 1'b1 && w < 100) begin @(negedge Clock); w++; end
        e = model(op, a, b, cf);
        cf = e.c;
        sb.push_back(e);
        InValid = 1'b1; Opcode = op; OperandA = a; OperandB = b;
        @(posedge Clock);
        #1;
        InValid = 1'b0; Opcode = 5'($urandom); OperandA = 16'($urandom); OperandB = 16'($urandom);
        lat = 1;
        @(negedge Clock);
        while (OutValid !== 1'b1 && lat < 100) begin @(negedge Clock); lat++; end
        got = {Result, Carry, Overflow, Zero, Negative, Error, 32'(lat)};
        OutReady = 1'b1;
        @(posedge Clock);
        #1 OutReady = 1'b0;
    endtask

    task automatic test_reset();
        ResetN = 1'b0;
        #12;
        checks++;
        if ({InReady, OutValid, Result, Carry, Overflow, Zero, Negative, Error} !== {1'b1, 1'b0, 16'h0, 5'b0}) begin
            fails++;
            $display("FAIL reset_state: got rdy=%b vld=%b res=%h flags=%b, want rdy=1 vld=0 res=0000 flags=00000",
                     InReady, OutValid, Result, {Carry, Overflow, Zero, Negative, Error});
        end
        @(negedge Clock);
        ResetN = 1'b1;
        cf = 1'b0;
    endtask

    task automatic test_add();
        rec_t got, e;
        do_op(5'd4, 16'h7FFF, 16'h0001, got);
        e = sb.pop_front();
        checks++;
        if (got !== e) begin fails++; $display("FAIL add_model: got %s want %s", fmt(got), fmt(e)); end
        checks++;
        if (got.res !== 16'h8000 || got.v !== 1'b1 || got.c !== 1'b0 || got.n !== 1'b1 || got.z !== 1'b0 || got.lat !== 32'd1) begin
            fails++;
            $display("FAIL add_7fff_1: got %s want res=8000 c=0 v=1 z=0 n=1 lat=1", fmt(got));
        end
    endtask

    task automatic test_carry_chain();
        logic [4:0]  ops [3] = '{5'd5, 5'd6, 5'd7};
        logic [15:0] as  [3] = '{16'h0000, 16'h0001, 16'h0005};
        logic [15:0] want[3] = '{16'hFFFF, 16'h0003, 16'h0004};
        logic        wc  [3] = '{1'b1, 1'b0, 1'b0};
        rec_t got, e;
        for (int i = 0; i < 3; i++) begin
            do_op(ops[i], as[i], 16'h0001, got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin fails++; $display("FAIL chain_model[%0d]: got %s want %s", i, fmt(got), fmt(e)); end
            checks++;
            if (got.res !== want[i] || got.c !== wc[i]) begin
                fails++;
                $display("FAIL chain_const[%0d]: got res=%h c=%b want res=%h c=%b", i, got.res, got.c, want[i], wc[i]);
            end
        end
    endtask

    task automatic test_shifts();
        logic [4:0]  ops [6] = '{5'd8, 5'd10, 5'd9, 5'd9, 5'd8, 5'd9};
        logic [15:0] as  [6] = '{16'h8001, 16'h8000, 16'h0001, 16'h1234, 16'h00F0, 16'h00F0};
        logic [15:0] bs  [6] = '{16'h0004, 16'h000F, 16'h0001, 16'h0000, 16'h0013, 16'hFF02};
        logic [15:0] want[6] = '{16'h0010, 16'hFFFF, 16'h0000, 16'h1234, 16'h0780, 16'h003C};
        int          wlat[6] = '{5, 16, 2, 1, 4, 3};
        rec_t got, e;
        for (int i = 0; i < 6; i++) begin
            do_op(ops[i], as[i], bs[i], got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin fails++; $display("FAIL shift_model[%0d]: got %s want %s", i, fmt(got), fmt(e)); end
            checks++;
            if (got.res !== want[i] || got.lat !== 32'(wlat[i])) begin
                fails++;
                $display("FAIL shift_const[%0d]: got res=%h lat=%0d want res=%h lat=%0d", i, got.res, got.lat, want[i], wlat[i]);
            end
        end
        // The shift-by-0 row follows a carry-setting shift, so carry must still be 1 there.
    endtask

    task automatic test_mul();
        logic [4:0]  ops [4] = '{5'd11, 5'd12, 5'd11, 5'd12};
        logic [15:0] as  [4] = '{16'h0100, 16'h0100, 16'hFFFF, 16'hFFFF};
        logic [15:0] want[4] = '{16'h0000, 16'h0001, 16'h0001, 16'hFFFE};
        logic        wv  [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
        rec_t got, e;
        for (int i = 0; i < 4; i++) begin
            do_op(ops[i], as[i], as[i], got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin fails++; $display("FAIL mul_model[%0d]: got %s want %s", i, fmt(got), fmt(e)); end
            checks++;
            if (got.res !== want[i] || got.v !== wv[i] || got.lat !== 32'd17) begin
                fails++;
                $display("FAIL mul_const[%0d]: got res=%h v=%b lat=%0d want res=%h v=%b lat=17", i, got.res, got.v, got.lat, want[i], wv[i]);
            end
        end
    endtask

    task automatic test_random();
        rec_t got, e;
        logic [4:0] op;
        for (int i = 0; i < 24; i++) begin
            op = 5'($urandom_range(0, 15));
            do_op(op, 16'($urandom), 16'($urandom), got);
            e = sb.pop_front();
            checks++;
            if (got !== e) begin fails++; $display("FAIL random[%0d] op=%0d: got %s want %s", i, op, fmt(got), fmt(e)); end
        end
    endtask

    task automatic test_error();
        rec_t got, e;
        do_op(5'h1F, 16'hABCD, 16'h1234, got);
        e = sb.pop_front();
        checks++;
        if (got !== e || got.e !== 1'b1 || got.res !== 16'h0) begin
            fails++;
            $display("FAIL illegal_1f: got %s want %s", fmt(got), fmt(e));
        end
    endtask

    task automatic test_backpressure();
        rec_t e, snap;
        int   lat;
        @(negedge Clock);
        e = model(5'd4, 16'h1234, 16'h4321, cf);
        cf = e.c;
        sb.push_back(e);
        InValid = 1'b1; Opcode = 5'd4; OperandA = 16'h1234; OperandB = 16'h4321;
        @(posedge Clock);
        #1 InValid = 1'b0;
        lat = 1;
        @(negedge Clock);
        while (OutValid !== 1'b1 && lat < 100) begin @(negedge Clock); lat++; end
        snap = {Result, Carry, Overflow, Zero, Negative, Error, 32'(lat)};
        e = sb.pop_front();
        checks++;
        if (snap !== e) begin fails++; $display("FAIL bp_result: got %s want %s", fmt(snap), fmt(e)); end
        for (int i = 0; i < 10; i++) begin
            InValid = 1'b1; Opcode = 5'd2; OperandA = 16'($urandom); OperandB = 16'($urandom);
            @(negedge Clock);
            checks++;
            if ({InReady, OutValid, Result, Carry, Overflow, Zero, Negative, Error} !== {1'b0, 1'b1, e.res, e.c, e.v, e.z, e.n, e.e}) begin
                fails++;
                $display("FAIL bp_hold[%0d]: got rdy=%b vld=%b res=%h want rdy=0 vld=1 res=%h", i, InReady, OutValid, Result, e.res);
            end
        end
        InValid = 1'b0;
        OutReady = 1'b1;
        @(posedge Clock);
        #1 OutReady = 1'b0;
        @(negedge Clock);
        checks++;
        if (InReady !== 1'b1 || OutValid !== 1'b0) begin
            fails++;
            $display("FAIL bp_release: got rdy=%b vld=%b want rdy=1 vld=0", InReady, OutValid);
        end
    endtask

    task automatic test_reset_mid();
        rec_t got, e;
        logic [15:0] want[2] = '{16'h0005, 16'h0002};
        logic [4:0]  ops [2] = '{5'd4, 5'd6};
        logic [15:0] as  [2] = '{16'h0002, 16'h0001};
        logic [15:0] bs  [2] = '{16'h0003, 16'h0001};
        do_op(5'd5, 16'h0000, 16'h0001, got);
        e = sb.pop_front();
        checks++;
        if (got !== e) begin fails++; $display("FAIL rst_pre: got %s want %s", fmt(got), fmt(e)); end
        @(negedge Clock);
        InValid = 1'b1; Opcode = 5'd11; OperandA = 16'h00FF; OperandB = 16'h0003;
        @(posedge Clock);
        #1 InValid = 1'b0;
        repeat (4) @(posedge Clock);
        #1 ResetN = 1'b0;
        #1;
        cf = 1'b0;
        checks++;
        if ({InReady, OutValid, Result, Carry, Overflow, Zero, Negative, Error} !== {1'b1, 1'b0, 16'h0, 5'b0}) begin
            fails++;
            $display("FAIL rst_mid_mul: got rdy=%b vld=%b res=%h flags=%b want rdy=1 vld=0 res=0000 flags=00000",
                     InReady, OutValid, Result, {Carry, Overflow, Zero, Negative, Error});
        end
        repeat (2) @(negedge Clock);
        ResetN = 1'b1;
        for (int i = 0; i < 2; i++) begin
            do_op(ops[i], as[i], bs[i], got);
            e = sb.pop_front();
            checks++;
            if (got !== e || got.res !== want[i]) begin
                fails++;
                $display("FAIL rst_after[%0d]: got %s want res=%h (%s)", i, fmt(got), want[i], fmt(e));
            end
        end
    endtask

    initial begin
        test_reset();
        test_add();
        test_carry_chain();
        test_shifts();
        test_mul();
        test_error();
        test_backpressure();
        test_random();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule
